// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default bit timing,
// used by both the transmit and receive directions.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 87;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } uart_state_e;

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit,
// then a one-cycle CLEANUP state that pulses tx_done.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       hold_q, hold_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Outputs are computed for the next state so every pin comes straight from a flop.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    serial_d = serial_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        cnt_d    = '0;
        idx_d    = '0;
        if (tx_start) begin
          hold_d   = tx_data;
          serial_d = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d    = '0;
          idx_d    = '0;
          serial_d = hold_q[0];
          state_d  = ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = ST_STOP;
          end else begin
            idx_d    = idx_q + 3'd1;
            serial_d = hold_q[idx_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d    = '0;
          done_d   = 1'b1;
          serial_d = 1'b1;
          state_d  = ST_CLEANUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CLEANUP: begin
        cnt_d    = '0;
        serial_d = 1'b1;
        state_d  = ST_IDLE;
      end
      default: begin
        cnt_d    = '0;
        idx_d    = '0;
        serial_d = 1'b1;
        state_d  = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      hold_q   <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx_serial = serial_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a line
// monitor decodes each serial frame and checks it against the queue.
module tb_uart_tx;

  localparam int CLKS  = 87;
  localparam int FRAME = 10 * CLKS;

  logic       clk;
  logic       rst_n;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int         total;
  int         bad;
  int         cyc;
  int         done_count;
  int         expected_done;
  logic [7:0] exp_q[$];
  int         mon_starts[$];

  uart_tx #(.CLKS_PER_BIT(CLKS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (tx_done === 1'b1) done_count <= done_count + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sends one byte from idle; 'after' is put on tx_data one cycle after accept
  // and must not leak into the frame.
  task automatic applyStimulus(input logic [7:0] b, input logic [7:0] after);
    int n;
    @(posedge clk); #1;
    tx_data  = b;
    tx_start = 1'b1;
    exp_q.push_back(b);
    expected_done++;
    @(posedge clk); #1;
    tx_start = 1'b0;
    tx_data  = after;
    @(negedge clk);
    checkOutput("start_bit_visible", {31'd0, tx_serial}, 32'd0);
    checkOutput("busy_on_accept", {31'd0, tx_busy}, 32'd1);
    n = 0;
    while (tx_done !== 1'b1 && n < FRAME + 20) begin
      @(negedge clk);
      n++;
    end
    if (tx_done !== 1'b1) checkOutput("done_timeout", 32'd0, 32'd1);
  endtask

  // Line monitor: every frame is 10 bit periods from the first low cycle,
  // tx_done follows in the next cycle, and busy drops one cycle later.
  initial begin : monitor
    logic [FRAME-1:0] wave;
    logic [9:0]       frame;
    logic [7:0]       got;
    logic [7:0]       expb;
    logic             aborted, early_done, busy_gap;
    logic             done_at, busy_at, done_after, busy_after;
    int               errs;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_serial === 1'b0) begin
        mon_starts.push_back(cyc);
        wave       = '0;
        aborted    = 1'b0;
        early_done = 1'b0;
        busy_gap   = 1'b0;
        done_at    = 1'b0;
        busy_at    = 1'b0;
        done_after = 1'b1;
        busy_after = 1'b1;
        for (int i = 1; i < FRAME + 2; i++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (i < FRAME) begin
            wave[i] = tx_serial;
            if (tx_done !== 1'b0) early_done = 1'b1;
            if (tx_busy !== 1'b1) busy_gap = 1'b1;
          end else if (i == FRAME) begin
            done_at = tx_done;
            busy_at = tx_busy;
            if (tx_serial !== 1'b1) busy_gap = 1'b1;
          end else begin
            done_after = tx_done;
            busy_after = tx_busy;
          end
        end
        if (aborted) begin
          void'(mon_starts.pop_back());
        end else if (exp_q.size() == 0) begin
          checkOutput("unexpected_frame", 32'd1, 32'd0);
        end else begin
          expb  = exp_q.pop_front();
          frame = {1'b1, expb, 1'b0};
          for (int k = 0; k < 8; k++) got[k] = wave[(k + 1) * CLKS + CLKS / 2];
          errs = 0;
          for (int i = 0; i < FRAME; i++) if (wave[i] !== frame[i / CLKS]) errs++;
          checkOutput("frame_byte", {24'd0, got}, {24'd0, expb});
          checkOutput("frame_shape_errors", errs, 32'd0);
          checkOutput("start_stop_bits", {30'd0, wave[CLKS / 2], wave[9 * CLKS + CLKS / 2]}, 32'd1);
          checkOutput("done_timing", {29'd0, early_done, done_at, done_after}, 32'd2);
          checkOutput("busy_span", {29'd0, busy_gap, busy_at, busy_after}, 32'd2);
        end
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int         t, busy_cycles, n, d0, idle_err;
    logic       busy_seen;
    logic [7:0] b;
    total = 0; bad = 0; cyc = 0; done_count = 0; expected_done = 0;
    rst_n = 1'b0; tx_start = 1'b1; tx_data = 8'hA5;

    // Reset with tx_start high: must stay idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_serial", {31'd0, tx_serial}, 32'd1);
    checkOutput("reset_busy", {31'd0, tx_busy}, 32'd0);
    checkOutput("reset_done", {31'd0, tx_done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; tx_start = 1'b0;
    @(negedge clk);
    checkOutput("start_ignored_in_reset", {31'd0, tx_busy}, 32'd0);

    $display("[TB] directed bytes");
    applyStimulus(8'h3C, 8'hC3);
    applyStimulus(8'h00, 8'hFF);
    applyStimulus(8'hFF, 8'h00);
    applyStimulus(8'hA5, 8'h5A);
    applyStimulus(8'h5A, 8'hA5);

    // Extra tx_start pulses during DATA and during CLEANUP are dropped.
    $display("[TB] ignored start pulses");
    @(posedge clk); #1;
    tx_data = 8'h81; tx_start = 1'b1;
    exp_q.push_back(8'h81);
    expected_done++;
    busy_cycles = 0;
    t = 0;
    do begin
      @(posedge clk); #1;
      tx_start = (t == 100 || t == 500 || t == FRAME);
      tx_data  = tx_start ? 8'h7E : 8'h81;
      @(negedge clk);
      if (tx_busy === 1'b1) busy_cycles++;
      t++;
    end while (tx_busy === 1'b1 && t < 2000);
    @(posedge clk); #1;
    tx_start = 1'b0;
    checkOutput("busy_cycles", busy_cycles, FRAME + 1);
    busy_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (tx_busy !== 1'b0) busy_seen = 1'b1;
    end
    checkOutput("no_queued_frame", {31'd0, busy_seen}, 32'd0);

    // Held tx_start: frames back to back, CLEANUP then one IDLE cycle between.
    $display("[TB] held start");
    mon_starts.delete();
    d0 = done_count;
    @(posedge clk); #1;
    tx_data = 8'h55; tx_start = 1'b1;
    repeat (3) exp_q.push_back(8'h55);
    expected_done += 3;
    repeat (2 * (FRAME + 2) + 1) @(posedge clk);
    #1 tx_start = 1'b0;
    n = 0;
    while (done_count < d0 + 3 && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput("held_done_pulses", done_count - d0, 32'd3);
    checkOutput("held_frame_count", mon_starts.size(), 32'd3);
    if (mon_starts.size() == 3) begin
      checkOutput("held_spacing_1", mon_starts[1] - mon_starts[0], FRAME + 2);
      checkOutput("held_spacing_2", mon_starts[2] - mon_starts[1], FRAME + 2);
    end

    // One-cycle reset in the middle of data bit 4 aborts the frame silently.
    $display("[TB] reset mid-frame");
    @(posedge clk); #1;
    tx_data = 8'h3C; tx_start = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge clk); #1;
    tx_start = 1'b0;
    repeat (5 * CLKS + CLKS / 2) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(exp_q.pop_back());
    d0 = done_count;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_serial", {31'd0, tx_serial}, 32'd1);
    checkOutput("abort_busy", {31'd0, tx_busy}, 32'd0);
    idle_err = 0;
    repeat (6 * CLKS) begin
      @(negedge clk);
      if (tx_serial !== 1'b1 || tx_busy !== 1'b0) idle_err++;
    end
    checkOutput("abort_stays_idle", idle_err, 32'd0);
    checkOutput("abort_no_done", done_count - d0, 32'd0);
    applyStimulus(8'h3C, 8'hC3);

    $display("[TB] random bytes");
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      repeat ($urandom_range(0, 15)) @(posedge clk);
      applyStimulus(b, 8'($urandom));
    end

    repeat (20) @(negedge clk);
    checkOutput("queue_drained", exp_q.size(), 32'd0);
    checkOutput("total_done_pulses", done_count, expected_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
